ds2411_responder: RTL

//  1-Wire slave that emulates a DS2411 silicon serial number on an open-drain line. It detects the

---
 rtl/ow_pkg.sv | 27 ++
 rtl/ow_us_tick.sv | 21 ++
 rtl/ds2411_responder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ow_pkg.sv
// ow_pkg: shared 1-Wire types, command codes and default timing for the responder and the reader.
package ow_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRES_WAIT,
        ST_PRES,
        ST_CMD,
        ST_TX
    } ow_state_e;

    localparam logic [7:0] CMD_READ_ROM        = 8'h33;
    localparam logic [7:0] CMD_READ_ROM_LEGACY = 8'h0F;

    localparam int CLK_PER_US_DEF   = 100;
    localparam int RESET_MIN_US_DEF = 480;
    localparam int PRES_WAIT_US_DEF = 30;
    localparam int PRES_US_DEF      = 120;
    localparam int SAMPLE_US_DEF    = 30;
    localparam int HOLD0_US_DEF     = 30;
    localparam int US_W             = 9;

    function automatic logic is_read_rom(input logic [7:0] c);
        return (c == CMD_READ_ROM) || (c == CMD_READ_ROM_LEGACY);
    endfunction

endpackage

// File: rtl/ow_us_tick.sv
// ow_us_tick: free-running one-clock pulse every CLK_PER_US clocks.
module ow_us_tick #(
    parameter int CLK_PER_US = 100
) (
    input  logic clk,
    input  logic reset,
    output logic us_tick
);

    localparam int W = $clog2(CLK_PER_US + 1);

    logic [W-1:0] cnt_q;

    assign us_tick = cnt_q == W'(CLK_PER_US - 1);

    always_ff @(posedge clk) begin
        if (reset || us_tick) cnt_q <= '0;
        else cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/ds2411_responder.sv
// ds2411_responder: 1-Wire slave answering bus reset with presence and READ ROM with a 64-bit ID.
module ds2411_responder
    import ow_pkg::*;
#(
    parameter int CLK_PER_US   = CLK_PER_US_DEF,
    parameter int RESET_MIN_US = RESET_MIN_US_DEF,
    parameter int PRES_WAIT_US = PRES_WAIT_US_DEF,
    parameter int PRES_US      = PRES_US_DEF,
    parameter int SAMPLE_US    = SAMPLE_US_DEF,
    parameter int HOLD0_US     = HOLD0_US_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [63:0] rom_id,
    input  logic        dq_in,
    output logic        dq_oe,
    output logic        busy,
    output logic        reset_seen,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        cmd_unsupp,
    output logic        rom_sent
);

    ow_state_e        state_q, state_d;
    logic             s1_q, s2_q, prev_q;
    logic             fall, rise, us_tick, bus_rst, restart;
    logic             slot_start, tx_start, sample, hold_end, tx_done;
    logic [US_W-1:0]  low_q, low_d, t_q, t_d;
    logic             slot_q, slot_d, drv_q, drv_d;
    logic [6:0]       bit_q, bit_d;
    logic [7:0]       cmd_sh_q, cmd_sh_d, cmd_q, cmd_d, cmd_next;
    logic [63:0]      rom_q, rom_d;

    ow_us_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .us_tick(us_tick)
    );

    assign fall       = prev_q & ~s2_q;
    assign rise       = ~prev_q & s2_q;
    assign bus_rst    = rise && (low_q >= US_W'(RESET_MIN_US));
    assign cmd_next   = {s2_q, cmd_sh_q[7:1]};
    assign sample     = (state_q == ST_CMD) && slot_q && (t_q == US_W'(SAMPLE_US));
    assign hold_end   = (state_q == ST_TX) && slot_q && (t_q == US_W'(HOLD0_US));
    assign tx_start   = fall && !slot_q && (state_q == ST_TX) && (bit_q != 7'd64);
    assign slot_start = tx_start || (fall && !slot_q && (state_q == ST_CMD));
    assign tx_done    = (state_q == ST_TX) && (bit_q == 7'd64) && !slot_q && s2_q;
    assign restart    = (state_d != state_q) || bus_rst;

    always_ff @(posedge clk) begin
        state_q <= reset ? ST_IDLE : state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) state_d = ST_IDLE;
        else if (bus_rst) state_d = ST_PRES_WAIT;
        else begin
            case (state_q)
                ST_PRES_WAIT: state_d = (t_q == US_W'(PRES_WAIT_US)) ? ST_PRES : ST_PRES_WAIT;
                ST_PRES:      state_d = (t_q == US_W'(PRES_US)) ? ST_CMD : ST_PRES;
                ST_CMD:       if (sample && bit_q == 7'd7) state_d = is_read_rom(cmd_next) ? ST_TX : ST_IDLE;
                ST_TX:        state_d = tx_done ? ST_IDLE : ST_TX;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dq_oe      = enable && ((state_q == ST_PRES) || ((state_q == ST_TX) && drv_q));
        busy       = state_q != ST_IDLE;
        reset_seen = enable && bus_rst;
        cmd_valid  = enable && !bus_rst && sample && (bit_q == 7'd7);
        cmd_unsupp = cmd_valid && !is_read_rom(cmd_next);
        rom_sent   = enable && !bus_rst && tx_done;
        cmd_byte   = cmd_q;
    end

    // Low time is only the master's: our own drive must never build up a bus reset.
    always_comb begin
        low_d    = fall ? '0 : (us_tick && !s2_q && !dq_oe && low_q < US_W'(RESET_MIN_US)) ? low_q + 1'b1 : low_q;
        t_d      = (restart || slot_start) ? '0 : (us_tick && t_q != '1) ? t_q + 1'b1 : t_q;
        slot_d   = restart ? 1'b0 : slot_start ? 1'b1 : (sample || hold_end) ? 1'b0 : slot_q;
        drv_d    = (restart || !enable || hold_end) ? 1'b0 : tx_start ? ~rom_q[0] : drv_q;
        bit_d    = restart ? '0 : (sample || tx_start) ? bit_q + 1'b1 : bit_q;
        cmd_sh_d = sample ? cmd_next : cmd_sh_q;
        cmd_d    = cmd_valid ? cmd_next : cmd_q;
        rom_d    = (restart && state_d == ST_PRES_WAIT) ? rom_id : tx_start ? rom_q >> 1 : rom_q;
    end

    // Synchroniser idles high so a released bus does not look like an edge after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            prev_q   <= 1'b1;
            low_q    <= '0;
            t_q      <= '0;
            slot_q   <= 1'b0;
            drv_q    <= 1'b0;
            bit_q    <= '0;
            cmd_sh_q <= '0;
            cmd_q    <= '0;
            rom_q    <= '0;
        end else begin
            s1_q     <= dq_in;
            s2_q     <= s1_q;
            prev_q   <= s2_q;
            low_q    <= low_d;
            t_q      <= t_d;
            slot_q   <= slot_d;
            drv_q    <= drv_d;
            bit_q    <= bit_d;
            cmd_sh_q <= cmd_sh_d;
            cmd_q    <= cmd_d;
            rom_q    <= rom_d;
        end
    end

endmodule
